// File: rtl/npc_unit.sv
// rtl/npc_unit.sv - next-PC unit with exception entry/return; NPC_RAS_EN adds an advisory return-address stack
module npc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h180,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       pc_sel,
  input  logic             stall,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] address_b,
  input  logic [25:0]      address_j,
  input  logic [WIDTH-1:0] address_jr,
  input  logic             link,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam logic [2:0] SEL_PLUS4  = 3'd0;
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JUMP   = 3'd2;
  localparam logic [2:0] SEL_JUMPR  = 3'd3;
  localparam logic [2:0] SEL_ERET   = 3'd5;

  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] jump_target;
  logic             advance;
  logic             unused_bits;

  assign pc_plus4 = pc + WIDTH'(4);
  assign advance  = !reset && !exc_req && !stall;

  // Region bits come from pc+4 so a jump in a delay slot at a region edge lands in the next region.
  if (WIDTH > 28) begin : g_jump_hi
    assign jump_target = {pc_plus4[WIDTH-1:28], address_j, 2'b00};
  end else begin : g_jump_lo
    assign jump_target = {address_j, 2'b00};
  end

  always_comb begin
    pc_next = pc_plus4;
    case (pc_sel)
      SEL_BRANCH: pc_next = pc_plus4 + {address_b[WIDTH-3:0], 2'b00};
      SEL_JUMP:   pc_next = jump_target;
      SEL_JUMPR:  pc_next = {address_jr[WIDTH-1:2], 2'b00};
      SEL_ERET:   pc_next = epc;
      default:    pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= RESET_VECTOR;
      epc <= '0;
    end else if (exc_req) begin
      epc <= pc;
      pc  <= EXC_VECTOR;
    end else if (!stall) begin
      pc <= pc_next;
    end
  end

`ifdef NPC_RAS_EN
  localparam int PW = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;
  logic [PW-1:0]    ras_top_idx;
  logic [PW:0]      ras_cnt;
  logic             ras_push;
  logic             ras_pop;

  assign ras_push    = advance && (pc_sel == SEL_JUMP) && link;
  assign ras_pop     = advance && (pc_sel == SEL_JUMPR) && ret && !ras_empty;
  assign ras_top_idx = ras_ptr - 1'b1;
  assign ras_empty   = (ras_cnt == '0);
  assign ras_full    = (ras_cnt == (PW+1)'(RAS_DEPTH));
  assign ras_top     = ras_empty ? '0 : ras_mem[ras_top_idx];
  assign unused_bits = ^{address_b[WIDTH-1:WIDTH-2], address_jr[1:0]};

  // Circular buffer: a push when full overwrites the oldest slot and the count saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + 1'b1;
      if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
    end else if (ras_pop) begin
      ras_ptr <= ras_ptr - 1'b1;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ras_ptr] <= pc_plus4;
  end
`else
  assign ras_top     = '0;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
  assign unused_bits = ^{address_b[WIDTH-1:WIDTH-2], address_jr[1:0], link, ret, advance};
`endif

endmodule
